// File: rtl/mem_reinit_ctrl.sv
// Arbiter/sequencer sharing one simple-dual-port RAM between a user port and a reinit sweep.
// Optional readback verification of the sweep is built when REINIT_READBACK_EN is defined.
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 16384,
  parameter int ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [WID_MEM-1:0] fill_data,
  input  logic               usr_valid,
  output logic               usr_ready,
  input  logic               usr_we,
  input  logic [ADDR_W-1:0]  usr_addr,
  input  logic [WID_MEM-1:0] usr_wdata,
  output logic               usr_rvalid,
  output logic [WID_MEM-1:0] usr_rdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic               mem_we,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout
`ifdef REINIT_READBACK_EN
  , output logic             chk_err
`endif
);

  localparam int CNT_W = $clog2(DEPTH_MEM) + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, READBACK, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_acc;
  logic             fill_hs;

  // Next-state and RAM port steering; everything is forced quiet while reset is high
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    usr_ready  = 1'b0;
    fill_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_raddr  = '0;
    mem_din    = '0;
    rd_acc     = 1'b0;
    fill_hs    = 1'b0;
    usr_rdata  = usr_rvalid ? mem_dout : '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          usr_ready = 1'b1;
          if (usr_valid) begin
            if (usr_we) begin
              mem_we    = 1'b1;
              mem_waddr = usr_addr;
              mem_din   = usr_wdata;
            end else begin
              rd_acc    = 1'b1;
              mem_raddr = usr_addr;
            end
          end else begin
            rd_acc = 1'b0;
          end
          if (start) begin
            state_nxt = SWEEP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        SWEEP: begin
          busy       = 1'b1;
          fill_ready = 1'b1;
          if (fill_valid) begin
            fill_hs   = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(cnt);
            mem_din   = fill_data;
            if (cnt == CNT_W'(DEPTH_MEM - 1)) begin
              cnt_nxt = '0;
`ifdef REINIT_READBACK_EN
              state_nxt = READBACK;
`else
              state_nxt = FINISH;
`endif
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            fill_hs = 1'b0;
          end
        end
`ifdef REINIT_READBACK_EN
        // One address per cycle; the extra cycle at cnt==DEPTH_MEM collects the last word
        READBACK: begin
          busy = 1'b1;
          if (cnt == CNT_W'(DEPTH_MEM)) begin
            state_nxt = FINISH;
            cnt_nxt   = '0;
          end else begin
            mem_raddr = ADDR_W'(cnt);
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
`endif
        FINISH: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end else begin
      usr_rdata = '0;
    end
  end

  // State, sweep counter and read-return flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      usr_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      usr_rvalid <= rd_acc;
    end
  end

`ifdef REINIT_READBACK_EN
  logic [WID_MEM-1:0] fill_fold;
  logic [WID_MEM-1:0] rb_fold;

  // XOR signatures of written and read-back words; mem_dout at cnt=k is word k-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_fold <= '0;
      rb_fold   <= '0;
      chk_err   <= 1'b0;
    end else if (state == IDLE && start) begin
      fill_fold <= '0;
      rb_fold   <= '0;
      chk_err   <= 1'b0;
    end else if (fill_hs) begin
      fill_fold <= fill_fold ^ fill_data;
    end else if (state == READBACK && cnt != CNT_W'(0)) begin
      rb_fold <= rb_fold ^ mem_dout;
      if (cnt == CNT_W'(DEPTH_MEM)) begin
        chk_err <= ((rb_fold ^ mem_dout) != fill_fold);
      end
    end
  end
`endif

endmodule
